// File: rtl/risc_pkg.sv
// risc_pkg: shared opcode, bus-select and control-state definitions for the RISC machine.
package risc_pkg;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;
    localparam logic [2:0] SEL_R0 = 3'd0;
    localparam logic [2:0] SEL_R1 = 3'd1;
    localparam logic [2:0] SEL_R2 = 3'd2;
    localparam logic [2:0] SEL_R3 = 3'd3;
    localparam logic [2:0] SEL_PC = 3'd4;
    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_BUS1 = 2'd1;
    localparam logic [1:0] SEL_MEM  = 2'd2;
    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
        S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
    } state_t;
endpackage

// File: rtl/risc_control_unit.sv
// risc_control_unit: fetch/decode/execute sequencer producing all datapath strobes.
module risc_control_unit
    import risc_pkg::*;
#(
    parameter int WORD_SIZE   = 8,
    parameter int OPCODE_SIZE = 4,
    parameter int SEL1_SIZE   = 3,
    parameter int SEL2_SIZE   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_SIZE-1:0]   instruction,
    input  logic                   zero,
    output logic [3:0]             load_reg,
    output logic                   load_pc,
    output logic                   inc_pc,
    output logic [SEL1_SIZE-1:0]   sel_bus_1,
    output logic [SEL2_SIZE-1:0]   sel_bus_2,
    output logic                   load_ir,
    output logic                   load_add_r,
    output logic                   load_reg_y,
    output logic                   load_reg_z,
    output logic                   write,
    output logic                   halted
);
    state_t state, state_next;
    logic [OPCODE_SIZE-1:0] opcode;
    logic [1:0] src, dest;
    logic [2:0] s1;
    logic [1:0] s2;
    assign opcode = instruction[WORD_SIZE-1 -: OPCODE_SIZE];
    assign src = instruction[3:2];
    assign dest = instruction[1:0];
    assign sel_bus_1 = SEL1_SIZE'(s1);
    assign sel_bus_2 = SEL2_SIZE'(s2);
    assign halted = state == S_HALT;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_next;
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: state_next = S_FET1;
            S_FET1: state_next = S_FET2;
            S_FET2: state_next = S_DEC;
            S_DEC:
                case (opcode)
                    OP_NOP, OP_NOT:         state_next = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: state_next = S_EX1;
                    OP_RD:                  state_next = S_RD1;
                    OP_WR:                  state_next = S_WR1;
                    OP_BR:                  state_next = S_BR1;
                    OP_BRZ:                 state_next = zero ? S_BR1 : S_FET1;
                    default:                state_next = S_HALT;
                endcase
            S_RD1: state_next = S_RD2;
            S_WR1: state_next = S_WR2;
            S_BR1: state_next = S_BR2;
            S_EX1, S_RD2, S_WR2, S_BR2: state_next = S_FET1;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end
    // Second word of RD/WR/BR is an address; S_DEC points the address register at it.
    always_comb begin
        load_reg = 4'b0;
        load_pc = 1'b0;
        inc_pc = 1'b0;
        s1 = SEL_R0;
        s2 = SEL_ALU;
        load_ir = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        write = 1'b0;
        case (state)
            S_FET1: begin
                s1 = SEL_PC;
                s2 = SEL_BUS1;
                load_add_r = 1'b1;
            end
            S_FET2: begin
                s2 = SEL_MEM;
                load_ir = 1'b1;
                inc_pc = 1'b1;
            end
            S_DEC:
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        s1 = {1'b0, src};
                        s2 = SEL_BUS1;
                        load_reg_y = 1'b1;
                    end
                    OP_NOT: begin
                        s1 = {1'b0, src};
                        load_reg_z = 1'b1;
                        load_reg = 4'b1 << dest;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        s1 = SEL_PC;
                        s2 = SEL_BUS1;
                        load_add_r = 1'b1;
                    end
                    OP_BRZ: begin
                        s1 = zero ? SEL_PC : SEL_R0;
                        s2 = zero ? SEL_BUS1 : SEL_ALU;
                        load_add_r = zero;
                        inc_pc = !zero;
                    end
                    default: ;
                endcase
            S_EX1: begin
                s1 = {1'b0, dest};
                load_reg_z = 1'b1;
                load_reg = 4'b1 << dest;
            end
            S_RD1, S_WR1: begin
                s2 = SEL_MEM;
                load_add_r = 1'b1;
                inc_pc = 1'b1;
            end
            S_RD2: begin
                s2 = SEL_MEM;
                load_reg = 4'b1 << dest;
            end
            S_WR2: begin
                s1 = {1'b0, src};
                write = 1'b1;
            end
            S_BR1: begin
                s2 = SEL_MEM;
                load_add_r = 1'b1;
            end
            S_BR2: begin
                s2 = SEL_MEM;
                load_pc = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_risc_control_unit.sv
// tb_risc_control_unit: randomized instruction streams checked cycle by cycle against a micro-op model.
module tb_risc_control_unit;
    typedef struct packed {
        logic [3:0] lr;
        logic lpc, ipc;
        logic [2:0] s1;
        logic [1:0] s2;
        logic lir, lar, lry, lrz, wr, hlt;
    } out_t;
    logic clk = 0, rst_n = 0, zero = 0;
    logic [7:0] instruction = 0;
    logic [3:0] load_reg;
    logic load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write, halted;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    int tests = 0, fails = 0;
    out_t exp_q[$];
    risc_control_unit dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
        .load_reg(load_reg), .load_pc(load_pc), .inc_pc(inc_pc),
        .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2), .load_ir(load_ir),
        .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_reg_z(load_reg_z),
        .write(write), .halted(halted)
    );
    always #5 clk = ~clk;
    function automatic out_t actual();
        return {load_reg, load_pc, inc_pc, sel_bus_1, sel_bus_2, load_ir,
                load_add_r, load_reg_y, load_reg_z, write, halted};
    endfunction
    // Expected per-cycle outputs for one instruction, starting at the first fetch cycle.
    task automatic build(input logic [7:0] ins, input logic z);
        out_t o;
        int op = ins[7:4];
        logic [1:0] src = ins[3:2], dst = ins[1:0];
        exp_q.delete();
        o = '0; o.s1 = 4; o.s2 = 1; o.lar = 1; exp_q.push_back(o);
        o = '0; o.s2 = 2; o.lir = 1; o.ipc = 1; exp_q.push_back(o);
        o = '0;
        if (op > 8) begin
            exp_q.push_back(o);
            o.hlt = 1;
            repeat (20) exp_q.push_back(o);
        end else if (op == 0) exp_q.push_back(o);
        else if (op <= 3) begin
            o.s1 = {1'b0, src}; o.s2 = 1; o.lry = 1; exp_q.push_back(o);
            o = '0; o.s1 = {1'b0, dst}; o.lrz = 1; o.lr[dst] = 1; exp_q.push_back(o);
        end else if (op == 4) begin
            o.s1 = {1'b0, src}; o.lrz = 1; o.lr[dst] = 1; exp_q.push_back(o);
        end else if (op == 8 && !z) begin
            o.ipc = 1; exp_q.push_back(o);
        end else begin
            o.s1 = 4; o.s2 = 1; o.lar = 1; exp_q.push_back(o);
            o = '0; o.s2 = 2; o.lar = 1; o.ipc = (op == 5 || op == 6); exp_q.push_back(o);
            o = '0;
            if (op == 5) begin o.s2 = 2; o.lr[dst] = 1; end
            else if (op == 6) begin o.s1 = {1'b0, src}; o.wr = 1; end
            else begin o.s2 = 2; o.lpc = 1; end
            exp_q.push_back(o);
        end
    endtask
    task automatic check(input string name, input int step, input out_t e);
        tests++;
        if (actual() !== e) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, actual(), e);
        end
    endtask
    // zero is randomized outside the decode cycle to show it is ignored there.
    task automatic run_instr(input logic [7:0] ins, input logic z, input string name);
        build(ins, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) instruction = ins;
            zero = (i == 2) ? z : 1'($urandom);
            @(negedge clk);
            check(name, i, exp_q[i]);
        end
    endtask
    task automatic do_reset(input string name);
        rst_n = 0;
        @(negedge clk);
        check({name, "_asserted"}, 0, '0);
        rst_n = 1;
        #1;
        check({name, "_idle"}, 0, '0);
    endtask
    task automatic test_reset();
        do_reset("reset");
        build(8'h1B, 0);
        instruction = 8'h1B;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("reset_pre_ex1", i, exp_q[i]);
        end
        @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        check("reset_mid_ex1", 0, '0);
        rst_n = 1;
        #1;
        check("reset_idle_after", 0, '0);
        run_instr(8'h00, 0, "nop_after_reset");
    endtask
    task automatic test_add();
        run_instr(8'h1B, 0, "add");
        run_instr(8'h2E, 1, "sub");
        run_instr(8'h35, 0, "and_src_eq_dest");
        run_instr(8'h4C, 1, "not");
    endtask
    task automatic test_rd_wr();
        run_instr(8'h51, 0, "rd");
        run_instr(8'h68, 1, "wr");
        run_instr(8'h70, 0, "br");
    endtask
    task automatic test_brz();
        run_instr(8'h80, 1, "brz_taken");
        run_instr(8'h80, 0, "brz_not_taken");
    endtask
    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            logic [7:0] ins = {4'($urandom_range(0, 8)), 4'($urandom)};
            run_instr(ins, 1'($urandom), "random");
        end
    endtask
    task automatic test_illegal();
        run_instr(8'hF0, 0, "illegal_f0");
        do_reset("halt_clear");
        run_instr({4'($urandom_range(9, 15)), 4'($urandom)}, 1, "illegal_random");
        do_reset("halt_clear2");
        run_instr(8'h1B, 0, "add_after_halt");
    endtask
    initial begin
        test_reset();
        test_add();
        test_rd_wr();
        test_brz();
        test_back_to_back();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
